// File: rtl/mutative_reconfig_seq_if.sv
// Bundles the policy, CPU and datapath signals of the cache reconfiguration sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface mutative_reconfig_seq_if #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = $clog2(NUM_LINES)
);
  logic [1:0]        setup_req;
  logic              cpu_req;
  logic              cache_ready;
  logic              cpu_stall;
  logic              flush_valid;
  logic [LINE_W-1:0] flush_idx;
  logic              flush_ready;
  logic [1:0]        setup;
  logic              reconfig_busy;
  logic [15:0]       reconfig_count;

  modport slave (
    input  setup_req, cpu_req, cache_ready, flush_ready,
    output cpu_stall, flush_valid, flush_idx, setup, reconfig_busy, reconfig_count
  );

  modport master (
    output setup_req, cpu_req, cache_ready, flush_ready,
    input  cpu_stall, flush_valid, flush_idx, setup, reconfig_busy, reconfig_count
  );
endinterface

// File: rtl/mutative_reconfig_seq.sv
// Switches the mutative cache between organisations: stall CPU, drain the
// outstanding access, flush every line, then commit the new setup.
module mutative_reconfig_seq #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = $clog2(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mutative_reconfig_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [LINE_W-1:0] LAST_IDX = LINE_W'(NUM_LINES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        setup_q, setup_d;
  logic [1:0]        pending_q, pending_d;
  logic [LINE_W-1:0] idx_q, idx_d;
  logic              outstanding_q, outstanding_d;
  logic [15:0]       count_q, count_d;

  logic mismatch;
  logic stall;
  logic accept;

  // A request arriving in the same cycle as a new mismatch is already blocked.
  assign mismatch      = (bus.setup_req != setup_q);
  assign stall         = (state_q != S_IDLE) | mismatch;
  assign accept        = bus.cpu_req & ~stall;
  assign outstanding_d = accept | (outstanding_q & ~bus.cache_ready);

  assign bus.cpu_stall      = stall;
  assign bus.flush_valid    = (state_q == S_FLUSH);
  assign bus.flush_idx      = idx_q;
  assign bus.setup          = setup_q;
  assign bus.reconfig_busy  = (state_q != S_IDLE);
  assign bus.reconfig_count = count_q;

  always_comb begin
    state_d   = state_q;
    setup_d   = setup_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (mismatch) begin
          pending_d = bus.setup_req;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!outstanding_q) begin
          idx_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Index only advances on a handshake, so stalls never skip a line.
        if (bus.flush_ready) begin
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_COMMIT: begin
        setup_d = pending_q;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      setup_q       <= 2'd0;
      pending_q     <= 2'd0;
      idx_q         <= '0;
      outstanding_q <= 1'b0;
      count_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      setup_q       <= setup_d;
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_mutative_reconfig_seq.sv
// Directed bench for mutative_reconfig_seq: a vector table for reset and a basic
// switch, then hand-written drain, backpressure, request-change and reset sequences.
module tb_mutative_reconfig_seq;

  typedef struct {
    logic [1:0]  setupReq;
    logic        cpuReq;
    logic        cacheReady;
    logic        flushReady;
    logic        expStall;
    logic        expFlushValid;
    logic [3:0]  expIdx;
    logic [1:0]  expSetup;
    logic        expBusy;
    logic [15:0] expCount;
  } vec_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;
  vec_t tbl[$];

  mutative_reconfig_seq_if #(.NUM_LINES(16)) bus ();

  mutative_reconfig_seq #(.NUM_LINES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] sr, input logic cr, input logic crdy,
                              input logic fr, input logic st, input logic fv,
                              input int idx, input logic [1:0] su, input logic busy,
                              input int cnt);
    vec_t v;
    v.setupReq = sr;  v.cpuReq = cr;  v.cacheReady = crdy;  v.flushReady = fr;
    v.expStall = st;  v.expFlushValid = fv;  v.expIdx = 4'(idx);
    v.expSetup = su;  v.expBusy = busy;  v.expCount = 16'(cnt);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.setup_req   = v.setupReq;
    bus.cpu_req     = v.cpuReq;
    bus.cache_ready = v.cacheReady;
    bus.flush_ready = v.flushReady;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp("cpu_stall",      16'(bus.cpu_stall),     16'(v.expStall));
    cmp("flush_valid",    16'(bus.flush_valid),   16'(v.expFlushValid));
    cmp("flush_idx",      16'(bus.flush_idx),     16'(v.expIdx));
    cmp("setup",          16'(bus.setup),         16'(v.expSetup));
    cmp("reconfig_busy",  16'(bus.reconfig_busy), 16'(v.expBusy));
    cmp("reconfig_count", bus.reconfig_count,     v.expCount);
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic step(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst_n     = 1'b0;
    applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Reset state, and stall following the mismatch equation during reset.
    #7;
    checkOutput(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    bus.setup_req = 2'd2;
    #1;
    checkOutput(mk(2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    bus.setup_req = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle access then basic 0->2 switch; cpu_req in the mismatch cycle must be blocked.
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(2, 0, 0, 1, 1, 1, i, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 1, 1, 0, 15, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 1, 0, 0, 15, 2, 0, 1));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Drain: access accepted at T-1 holds S_DRAIN until cache_ready at T+4.
    step(mk(2, 1, 0, 1, 0, 0, 15, 2, 0, 1));
    step(mk(1, 1, 0, 1, 1, 0, 15, 2, 0, 1));
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 1, 1, 0, 15, 2, 1, 1));
    step(mk(1, 0, 1, 1, 1, 0, 15, 2, 1, 1));
    step(mk(1, 0, 0, 1, 1, 0, 15, 2, 1, 1));
    for (int i = 0; i < 16; i++) step(mk(1, 0, 0, 1, 1, 1, i, 2, 1, 1));
    step(mk(1, 0, 0, 1, 1, 0, 15, 2, 1, 1));
    step(mk(1, 0, 0, 1, 0, 0, 15, 1, 0, 2));

    // Backpressure on flush cycles 3 and 9: index holds, none skipped or repeated.
    step(mk(0, 0, 0, 1, 1, 0, 15, 1, 0, 2));
    step(mk(0, 0, 0, 1, 1, 0, 15, 1, 1, 2));
    begin
      int expIdx;
      expIdx = 0;
      for (int c = 1; c <= 18; c++) begin
        logic fr;
        fr = (c != 3) && (c != 9);
        step(mk(0, 0, 0, fr, 1, 1, expIdx, 1, 1, 2));
        if (fr) expIdx++;
      end
    end
    step(mk(0, 0, 0, 1, 1, 0, 15, 1, 1, 2));
    step(mk(0, 0, 0, 1, 0, 0, 15, 0, 0, 3));

    // Request changes 3->1 mid-flush: commit 3, then a second full sequence to 1.
    step(mk(3, 0, 0, 1, 1, 0, 15, 0, 0, 3));
    step(mk(3, 0, 0, 1, 1, 0, 15, 0, 1, 3));
    for (int i = 0; i < 16; i++) step(mk((i < 4) ? 2'd3 : 2'd1, 0, 0, 1, 1, 1, i, 0, 1, 3));
    step(mk(1, 0, 0, 1, 1, 0, 15, 0, 1, 3));
    step(mk(1, 0, 0, 1, 1, 0, 15, 3, 0, 4));
    step(mk(1, 0, 0, 1, 1, 0, 15, 3, 1, 4));
    for (int i = 0; i < 16; i++) step(mk(1, 0, 0, 1, 1, 1, i, 3, 1, 4));
    step(mk(1, 0, 0, 1, 1, 0, 15, 3, 1, 4));
    step(mk(1, 0, 0, 1, 0, 0, 15, 1, 0, 5));

    // Asynchronous reset while flushing idx 7, then restart from idx 0.
    step(mk(3, 0, 0, 1, 1, 0, 15, 1, 0, 5));
    step(mk(3, 0, 0, 1, 1, 0, 15, 1, 1, 5));
    for (int i = 0; i < 7; i++) step(mk(3, 0, 0, 1, 1, 1, i, 1, 1, 5));
    applyStimulus(mk(3, 0, 0, 1, 1, 1, 7, 1, 1, 5));
    @(negedge clk);
    checkOutput(mk(3, 0, 0, 1, 1, 1, 7, 1, 1, 5));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step(mk(3, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 16; i++) step(mk(3, 0, 0, 1, 1, 1, i, 0, 1, 0));
    step(mk(3, 0, 0, 1, 1, 0, 15, 0, 1, 0));
    step(mk(3, 0, 0, 1, 0, 0, 15, 3, 0, 1));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mutative_reconfig_seq.md
# mutative_reconfig_seq

Sequences the switch between cache organisations (direct-mapped, 2-way, 4-way, fully associative) in the mutative cache. The miss-classification policy requests a new organisation. This block then:
- stalls the CPU port,
- drains any in-flight access,
- flushes every line through a valid/ready command port,
- commits the new organisation to the datapath.

It sits between the policy controller and the cache datapath, and is the only driver of the datapath's `setup` input.

## Interface
Parameters:
- `NUM_LINES`, 16: lines to flush per reconfiguration; must be a power of two, ≥ 2.
- `LINE_W`, `$clog2(NUM_LINES)`: flush index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `setup_req` in 2: requested organisation from policy. 0 = DM, 1 = 2-way, 2 = 4-way, 3 = fully associative.
- `cpu_req` in 1: CPU access request (single outstanding access max).
- `cache_ready` in 1: datapath completed the outstanding access.
- `cpu_stall` out 1: CPU must not issue; a `cpu_req` seen while this is high is not accepted.
- `flush_valid` out 1: flush command valid (write back if dirty, then invalidate).
- `flush_idx` out `LINE_W`: line index of the current flush command.
- `flush_ready` in 1: datapath accepts the flush command this cycle.
- `setup` out 2: active organisation driven to the datapath.
- `reconfig_busy` out 1: high in any state other than S_IDLE.
- `reconfig_count` out 16: completed reconfigurations; saturates at 16'hFFFF.

## Operation
- States: S_IDLE, S_DRAIN, S_FLUSH, S_COMMIT.
- `mismatch` = (`setup_req` != `setup`).
- `cpu_stall` is combinational: (state != S_IDLE) | `mismatch`. A request in the same cycle a mismatch appears is therefore blocked.
- An access is accepted when `cpu_req` & !`cpu_stall`.
- `outstanding` register, next value = accept | (`outstanding` & !`cache_ready`).
- S_IDLE:
  - On `mismatch`: capture `pending` <= `setup_req`, go to S_DRAIN.
  - Otherwise stay.
- S_DRAIN: when `outstanding` == 0, clear `idx` <= 0 and go to S_FLUSH. If `outstanding` is already 0 on entry, the state lasts exactly one cycle.
- S_FLUSH:
  - `flush_valid` = 1, `flush_idx` = `idx`.
  - On `flush_ready`: if `idx` == `NUM_LINES`-1, go to S_COMMIT; else `idx` <= `idx`+1.
  - Without `flush_ready`, `flush_valid` and `flush_idx` hold stable.
- S_COMMIT (one cycle):
  - `setup` <= `pending`.
  - `reconfig_count` <= `reconfig_count`+1 unless saturated.
  - Go to S_IDLE.
- `setup_req` changes after capture are ignored until S_IDLE. The new value is then re-evaluated, so back-to-back requests cause a second full sequence.
- `setup_req` == `setup` on return to S_IDLE: no sequence; stall drops.
- `flush_valid` is 0 outside S_FLUSH; `flush_idx` drives `idx` at all times.
- Every reconfiguration flushes all lines, including no-op-looking transitions and shrinking associativity; there is no partial flush.

## Timing
- Reset values (asserted asynchronously, held while `rst_n` = 0):
  - state = S_IDLE; `setup` = 0 (DM); `pending` = 0; `idx` = 0.
  - `outstanding` = 0; `reconfig_count` = 0.
  - `flush_valid` = 0; `reconfig_busy` = 0.
  - `cpu_stall` follows its equation, i.e. it is high iff `setup_req` != 0.
- Reset mid-sequence aborts immediately and `setup` returns to 0. The datapath shares the reset, so no partial state survives.
- Latency, with no outstanding access and `flush_ready` tied high, when `mismatch` first appears in cycle T:
  - T+1: S_DRAIN.
  - T+2 .. T+1+`NUM_LINES`: S_FLUSH, first `flush_valid` at T+2.
  - T+2+`NUM_LINES`: S_COMMIT.
  - T+3+`NUM_LINES`: new `setup` visible, S_IDLE, `cpu_stall` low. Total: `NUM_LINES`+3 cycles.
- Each cycle `flush_ready` is low in S_FLUSH adds one cycle.
- An outstanding access extends S_DRAIN until the cycle `cache_ready` is sampled high. S_FLUSH is entered on the following edge.
- `cache_ready` with no outstanding access is ignored.

## Test plan
- Reset/idle: hold `rst_n` = 0, `setup_req` = 0 → `setup` = 0, `cpu_stall` = 0, `flush_valid` = 0, `reconfig_count` = 0. Then `cpu_req` pulses → accepted, no stall.
- Basic switch: `NUM_LINES` = 16, `flush_ready` = 1, `setup_req` 0→2 at T → `flush_idx` 0..15 on T+2..T+17; `setup` = 2 and `cpu_stall` = 0 at T+19; `reconfig_count` = 1.
- Drain: accept `cpu_req` at T−1, `setup_req` 0→1 at T, `cache_ready` high at T+4 → no `flush_valid` before T+5. `cpu_req` at T is not accepted.
- Backpressure: `flush_ready` low on the 3rd and 9th flush cycles → `flush_idx` held for 2 cycles each time; commit delayed by 2 cycles; no index skipped or repeated.
- Request change mid-flush: `setup_req` 0→3, then 3→1 during S_FLUSH → commit `setup` = 3, then a second full sequence ending at `setup` = 1; `reconfig_count` = 2.
- Async reset during S_FLUSH at `idx` = 7 → outputs return to reset values immediately, without waiting for a clock edge. After release with `setup_req` = 3, the sequence restarts from `flush_idx` 0.
